// File: rtl/addr_trans_pkg.sv
// Shared types and constants for the address translation unit.
// Request types, exception codes and page sizes.
package addr_trans_pkg;

  typedef enum logic [1:0] {
    RT_FETCH = 2'd0,
    RT_LOAD  = 2'd1,
    RT_STORE = 2'd2
  } req_type_e;

  localparam logic [5:0] ECODE_NONE = 6'h00;
  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PME  = 6'h04;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_TLBR = 6'h3F;

  localparam logic [5:0] PS_4K = 6'd12;
  localparam logic [5:0] PS_4M = 6'd22;

  typedef struct packed {
    logic [31:0] pa;
    logic [1:0]  mat;
    logic        ex;
    logic [5:0]  ecode;
  } xlat_t;

endpackage

// File: rtl/addr_trans_dmw.sv
// Direct-mapped window match for one DMW register.
// PLV1/PLV2 never hit a window.
module dmw_match (
  input  logic [31:0] dmw,
  input  logic [31:0] va,
  input  logic [1:0]  plv,
  output logic        hit,
  output logic [31:0] pa,
  output logic [1:0]  mat
);

  logic plv_ok;
  logic unused_bits;

  // privilege enable bit selected by current level
  always_comb begin
    plv_ok = 1'b0;
    unique case (plv)
      2'd0:    plv_ok = dmw[0];
      2'd3:    plv_ok = dmw[3];
      default: plv_ok = 1'b0;
    endcase
  end

  assign hit = plv_ok && (dmw[31:29] == va[31:29]);
  assign pa  = {dmw[27:25], va[28:0]};
  assign mat = dmw[5:4];

  assign unused_bits = ^{dmw[28], dmw[24:6], dmw[2:1]};

endmodule

// File: rtl/addr_trans.sv
// Two-stage virtual-to-physical address translation.
// S1 holds the request and drives the TLB; S2 holds the response.
module addr_trans
  import addr_trans_pkg::*;
#(
  parameter int TLBNUM = 16,
  localparam int IW = (TLBNUM > 1) ? $clog2(TLBNUM) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_va,
  input  logic [1:0]    req_type,
  input  logic          csr_da,
  input  logic          csr_pg,
  input  logic [1:0]    csr_plv,
  input  logic [9:0]    csr_asid,
  input  logic [1:0]    csr_datf,
  input  logic [1:0]    csr_datm,
  input  logic [31:0]   csr_dmw0,
  input  logic [31:0]   csr_dmw1,
  output logic [18:0]   s_vppn,
  output logic          s_va_bit12,
  output logic [9:0]    s_asid,
  input  logic          s_found,
  input  logic [IW-1:0] s_index,
  input  logic [19:0]   s_ppn,
  input  logic [5:0]    s_ps,
  input  logic [1:0]    s_plv,
  input  logic [1:0]    s_mat,
  input  logic          s_d,
  input  logic          s_v,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_pa,
  output logic [1:0]    rsp_mat,
  output logic          rsp_ex,
  output logic [5:0]    rsp_ecode,
  output logic [15:0]   miss_cnt
);

  logic        s1_valid_q, s1_valid_d;
  logic [31:0] s1_va_q, s1_va_d;
  logic [1:0]  s1_type_q, s1_type_d;
  logic        rsp_valid_q, rsp_valid_d;
  xlat_t       rsp_q, rsp_d, xlat;
  logic [15:0] miss_cnt_q, miss_cnt_d;
  logic        s2_free, move, accept;
  logic        hit0, hit1;
  logic [31:0] pa0, pa1, tlb_pa;
  logic [1:0]  mat0, mat1;
  logic [5:0]  tlb_ecode;
  logic        unused_ok;

  assign s2_free   = ~rsp_valid_q | rsp_ready;
  assign req_ready = ~flush & (~s1_valid_q | s2_free);
  assign move      = s1_valid_q & s2_free;
  assign accept    = req_valid & req_ready;

  assign s_vppn     = s1_va_q[31:13];
  assign s_va_bit12 = s1_va_q[12];
  assign s_asid     = csr_asid;

  assign rsp_valid = rsp_valid_q;
  assign rsp_pa    = rsp_q.pa;
  assign rsp_mat   = rsp_q.mat;
  assign rsp_ex    = rsp_q.ex;
  assign rsp_ecode = rsp_q.ecode;
  assign miss_cnt  = miss_cnt_q;

  assign unused_ok = ^s_index;

  dmw_match u_dmw0 (
    .dmw (csr_dmw0),
    .va  (s1_va_q),
    .plv (csr_plv),
    .hit (hit0),
    .pa  (pa0),
    .mat (mat0)
  );

  dmw_match u_dmw1 (
    .dmw (csr_dmw1),
    .va  (s1_va_q),
    .plv (csr_plv),
    .hit (hit1),
    .pa  (pa1),
    .mat (mat1)
  );

  assign tlb_pa = (s_ps == PS_4M) ? {s_ppn[19:10], s1_va_q[21:0]}
                                  : {s_ppn, s1_va_q[11:0]};

  // TLB exception check in priority order
  always_comb begin
    tlb_ecode = ECODE_NONE;
    if (!s_found) begin
      tlb_ecode = ECODE_TLBR;
    end else if (!s_v) begin
      unique case (s1_type_q)
        RT_FETCH: tlb_ecode = ECODE_PIF;
        RT_STORE: tlb_ecode = ECODE_PIS;
        default:  tlb_ecode = ECODE_PIL;
      endcase
    end else if (csr_plv > s_plv) begin
      tlb_ecode = ECODE_PPI;
    end else if (s1_type_q == RT_STORE && !s_d) begin
      tlb_ecode = ECODE_PME;
    end
  end

  // select direct, window or TLB translation for S1
  always_comb begin
    xlat = '0;
    if (csr_da || !csr_pg) begin
      xlat.pa  = s1_va_q;
      xlat.mat = (s1_type_q == RT_FETCH) ? csr_datf : csr_datm;
    end else if (hit0) begin
      xlat.pa  = pa0;
      xlat.mat = mat0;
    end else if (hit1) begin
      xlat.pa  = pa1;
      xlat.mat = mat1;
    end else if (tlb_ecode != ECODE_NONE) begin
      xlat.ex    = 1'b1;
      xlat.ecode = tlb_ecode;
    end else begin
      xlat.pa  = tlb_pa;
      xlat.mat = s_mat;
    end
  end

  // pipeline advance, flush and miss counting
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_va_d     = s1_va_q;
    s1_type_d   = s1_type_q;
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;
    miss_cnt_d  = miss_cnt_q;
    if (move) s1_valid_d = 1'b0;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_va_d    = req_va;
      s1_type_d  = req_type;
    end
    if (s2_free) begin
      rsp_valid_d = move;
      if (move) rsp_d = xlat;
    end
    if (rsp_valid_q && rsp_ready && !flush && rsp_q.ecode == ECODE_TLBR)
      miss_cnt_d = miss_cnt_q + 16'd1;
    if (flush) begin
      s1_valid_d  = 1'b0;
      rsp_valid_d = 1'b0;
    end
  end

  // state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_va_q     <= '0;
      s1_type_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      miss_cnt_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_va_q     <= s1_va_d;
      s1_type_q   <= s1_type_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

endmodule
